fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the 20-bit instruction pointer register (`ipreg`) and the instruction memory port. It issues one word fetch at the current IP, hands the word to the decoder over a valid/ready handshake, then pulses `ipreg`'s increment input. Branch redirects are applied by loading `ipreg` with a target. The block sits between `ipreg`, the memory bus and the decode stage.

## Interface
- `ADDR_W`, 20, address / IP width
- `DATA_W`, 16, instruction word width
- `TIMEOUT`, 15, max cycles waiting for `mem_ack` (used only with `FETCH_TIMEOUT_EN`)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `run`  in  1  fetch enable
- `ip`  in  ADDR_W  current value from `ipreg.data_out`
- `ip_inc`  out  1  one-cycle increment pulse to `ipreg.inc`
- `ip_load`  out  1  one-cycle load pulse to `ipreg`
- `ip_load_val`  out  ADDR_W  load value for `ipreg.data_in`
- `mem_req`  out  1  fetch request, held until acked
- `mem_addr`  out  ADDR_W  equals `ip` while `mem_req`=1, else 0
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  DATA_W  read data
- `instr_valid`  out  1  instruction word valid to decoder
- `instr`  out  DATA_W  registered instruction word
- `instr_ready`  in  1  decoder accepts `instr`
- `br_valid`  in  1  redirect request (single-cycle pulse)
- `br_target`  in  ADDR_W  redirect address
- `fault`  out  1  sticky bus-timeout flag

## Operation
- States: IDLE, REQ, HOLD, DRAIN, REDIRECT, FAULT.
- IDLE: all outputs low. `run`=1 → REQ.
- REQ: `mem_req`=1. On `mem_ack`: `instr`←`mem_rdata`, `instr_valid`←1, `ip_inc` pulses next cycle, → HOLD. `run` falling during REQ does not abort the fetch.
- HOLD: `instr_valid` held, `instr` stable until `instr_ready`. On handshake: `run`=1 → REQ, else → IDLE.
- `br_valid` (any state except FAULT): `ip_load`=1 and `ip_load_val`=`br_target` next cycle; `instr_valid` cleared next cycle.
  - From REQ without same-cycle ack → DRAIN: keep `mem_req` until `mem_ack`, discard data, no `ip_inc`, → REDIRECT.
  - From REQ with same-cycle `mem_ack`: data discarded, no `ip_inc`, → REDIRECT.
  - From HOLD (with or without `instr_ready`) or IDLE → REDIRECT.
- REDIRECT: one settle cycle (ipreg updates); → REQ if `run`, else IDLE.
- `br_valid` during DRAIN/REDIRECT: latest target wins; `ip_load` re-pulses, DRAIN continues until ack.
- `ip_inc` and `ip_load` never high together. `ip_load_val` is 0 when `ip_load`=0.

## Timing
- Reset: state IDLE; `ip_inc`, `ip_load`, `ip_load_val`, `mem_req`, `mem_addr`, `instr_valid`, `instr`, `fault` all 0. Reset mid-fetch drops `mem_req` immediately; bus must tolerate abandonment.
- Ack in cycle t → `instr_valid`=1 and `ip_inc`=1 in t+1; `ipreg` holds ip+1 from t+2.
- Peak throughput: one word per 2 cycles (REQ with zero-wait ack, HOLD with `instr_ready`=1).
- `br_valid` in cycle t (HOLD) → `ip_load` in t+1, REDIRECT t+1, `mem_req` with new `mem_addr` in t+2.
- `mem_addr` combinational from `ip`; `ip` is stable throughout REQ.

## Configuration
- `FETCH_TIMEOUT_EN` defined: cycle counter runs in REQ/DRAIN, cleared on ack or state exit. `TIMEOUT` consecutive un-acked cycles → FAULT: `mem_req`=0, `instr_valid`=0, `fault`=1. FAULT is left only by `reset`; `br_valid` is ignored in FAULT.
- Undefined: no counter, FAULT unreachable, `fault` tied 0, waits indefinitely for `mem_ack`.

## Structure
- `fetch_pkg`: state enum, default `ADDR_W`/`DATA_W`/`TIMEOUT` constants.
- Sub-module `fetch_timer` (timeout counter with clear/expire), instantiated only under `FETCH_TIMEOUT_EN`.
- The FSM and output registers stay in `fetch_sequencer`.

## Test plan
- Reset asserted mid-REQ → all outputs 0 in the same cycle; state IDLE after release.
- `run`=1, ip=0x00000, `mem_ack` one cycle after request with 0x1234, `instr_ready`=1 → `instr`=0x1234, one `ip_inc` pulse; next `mem_addr`=0x00001.
- `instr_ready` low 3 cycles in HOLD → `instr` stable, no second `mem_req`, exactly one `ip_inc`.
- `br_valid` with target 0xABCDE in REQ, ack 2 cycles later with 0xFFFF → data discarded, no `ip_inc`, `ip_load` pulse with 0xABCDE, next `mem_addr`=0xABCDE.
- `br_valid` and `mem_ack` in the same cycle → no `instr_valid`, no `ip_inc`, redirect taken.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT`=15, `mem_ack` never returns → `fault`=1 after 15 cycles of `mem_req`, then `mem_req`=0 and `fault` stays 1 until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default sizes for the instruction-fetch sequencer
package fetch_pkg;
    localparam int FETCH_ADDR_W  = 20;
    localparam int FETCH_DATA_W  = 16;
    localparam int FETCH_TIMEOUT = 15;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_REDIRECT,
        S_FAULT
    } state_t;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive un-acked bus cycles and flags expiry
// Ports: clk, reset (async, active-high), active (count enable), clear (restart),
//        expire (high in the TIMEOUT-th consecutive active, un-cleared cycle)
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign expire = active && !clear && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (active && !clear) ? cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences ipreg and the instruction memory port, hands words to decode
// Ports: clk, reset (async, active-high), run, ip (from ipreg), ip_inc/ip_load/ip_load_val
//        (to ipreg), mem_req/mem_addr/mem_ack/mem_rdata (memory bus), instr_valid/instr/
//        instr_ready (decode handshake), br_valid/br_target (redirect), fault (sticky timeout)
// Option: define FETCH_TIMEOUT_EN to enable the bus timeout and the FAULT state.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = FETCH_TIMEOUT
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] ip,
    output logic              ip_inc,
    output logic              ip_load,
    output logic [ADDR_W-1:0] ip_load_val,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    input  logic              instr_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              fault
);
    state_t state;
    logic   expire;
    logic   take_br;
    // Request is a pure decode of the state register so reset drops it immediately.
    assign mem_req  = state == S_REQ || state == S_DRAIN;
    assign mem_addr = mem_req ? ip : '0;
`ifdef FETCH_TIMEOUT_EN
    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .active(mem_req),
        .clear (mem_ack || (state == S_REQ && br_valid)),
        .expire(expire)
    );
    assign fault = state == S_FAULT;
`else
    assign expire = 1'b0;
    assign fault  = 1'b0;
`endif
    // A timeout outranks a redirect arriving in the same cycle.
    assign take_br = br_valid && state != S_FAULT && !expire;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ip_inc      <= 1'b0;
            ip_load     <= 1'b0;
            ip_load_val <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
        end else begin
            ip_inc      <= 1'b0;
            ip_load     <= take_br;
            ip_load_val <= take_br ? br_target : '0;
            if (expire) begin
                state       <= S_FAULT;
                instr_valid <= 1'b0;
            end else if (take_br) begin
                // An outstanding request must still be drained before redirecting.
                instr_valid <= 1'b0;
                state       <= (mem_req && !mem_ack) ? S_DRAIN : S_REDIRECT;
            end else begin
                case (state)
                    S_IDLE:
                        if (run) state <= S_REQ;
                    S_REQ:
                        if (mem_ack) begin
                            instr       <= mem_rdata;
                            instr_valid <= 1'b1;
                            ip_inc      <= 1'b1;
                            state       <= S_HOLD;
                        end
                    S_HOLD:
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            state       <= run ? S_REQ : S_IDLE;
                        end
                    S_DRAIN:
                        if (mem_ack) state <= S_REDIRECT;
                    S_REDIRECT:
                        state <= run ? S_REQ : S_IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table, corner sequences and randomized run against a fetch model
module tb_fetch_sequencer;
    import fetch_pkg::*;
    localparam int AW = FETCH_ADDR_W;
    localparam int DW = FETCH_DATA_W;
    localparam int NV = 28;

    logic          clk = 1'b0, reset = 1'b1, run = 1'b0, mem_ack = 1'b0;
    logic          instr_ready = 1'b0, br_valid = 1'b0;
    logic [AW-1:0] ip, br_target = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          ip_inc, ip_load, mem_req, instr_valid, fault;
    logic [AW-1:0] ip_load_val, mem_addr;
    logic [DW-1:0] instr;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ip         (ip),
        .ip_inc     (ip_inc),
        .ip_load    (ip_load),
        .ip_load_val(ip_load_val),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .fault      (fault)
    );

    // ipreg as seen by the sequencer
    always @(posedge clk or posedge reset)
        if (reset) ip <= '0;
        else if (ip_load) ip <= ip_load_val;
        else if (ip_inc) ip <= ip + 1'b1;

    typedef struct {
        bit            run, ack;
        logic [DW-1:0] rdata;
        bit            rdy, br;
        logic [AW-1:0] tgt;
        bit            req;
        logic [AW-1:0] addr;
        bit            vld;
        logic [DW-1:0] ins;
        bit            inc, ld;
        logic [AW-1:0] lval;
    } vec_t;
    vec_t v[NV];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A5};
    endfunction

    function automatic logic [63:0] obs();
        return {3'b0, mem_req, mem_addr, instr_valid, instr, ip_inc, ip_load, ip_load_val, fault};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit a, input logic [DW-1:0] d, input bit rd,
                         input bit b, input logic [AW-1:0] t);
        @(posedge clk);
        #1;
        run = r; mem_ack = a; mem_rdata = d; instr_ready = rd; br_valid = b; br_target = t;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; run = 0; mem_ack = 0; instr_ready = 0; br_valid = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_pc, prev_tgt;
        bit            prev_br;
        int            words, cnt;
        // run ack rdata rdy br tgt | req addr vld instr inc ld lval
        v[0]  = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h0,    0, 0, 20'h0};
        v[1]  = '{1, 0, 16'h0,    0, 0, 20'h0,     1, 20'h0,     0, 16'h0,    0, 0, 20'h0};
        v[2]  = '{1, 1, 16'h1234, 0, 0, 20'h0,     1, 20'h0,     0, 16'h0,    0, 0, 20'h0};
        v[3]  = '{1, 0, 16'h0,    1, 0, 20'h0,     0, 20'h0,     1, 16'h1234, 1, 0, 20'h0};
        v[4]  = '{1, 1, 16'h2222, 0, 0, 20'h0,     1, 20'h1,     0, 16'h1234, 0, 0, 20'h0};
        v[5]  = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     1, 16'h2222, 1, 0, 20'h0};
        v[6]  = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     1, 16'h2222, 0, 0, 20'h0};
        v[7]  = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     1, 16'h2222, 0, 0, 20'h0};
        v[8]  = '{1, 0, 16'h0,    1, 0, 20'h0,     0, 20'h0,     1, 16'h2222, 0, 0, 20'h0};
        v[9]  = '{1, 0, 16'h0,    0, 1, 20'hABCDE, 1, 20'h2,     0, 16'h2222, 0, 0, 20'h0};
        v[10] = '{1, 0, 16'h0,    0, 0, 20'h0,     1, 20'h2,     0, 16'h2222, 0, 1, 20'hABCDE};
        v[11] = '{1, 1, 16'hFFFF, 0, 0, 20'h0,     1, 20'hABCDE, 0, 16'h2222, 0, 0, 20'h0};
        v[12] = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h2222, 0, 0, 20'h0};
        v[13] = '{1, 1, 16'h5555, 0, 1, 20'h12345, 1, 20'hABCDE, 0, 16'h2222, 0, 0, 20'h0};
        v[14] = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h2222, 0, 1, 20'h12345};
        v[15] = '{0, 1, 16'h0BEE, 0, 0, 20'h0,     1, 20'h12345, 0, 16'h2222, 0, 0, 20'h0};
        v[16] = '{0, 0, 16'h0,    0, 1, 20'h10,    0, 20'h0,     1, 16'h0BEE, 1, 0, 20'h0};
        v[17] = '{0, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h0BEE, 0, 1, 20'h10};
        v[18] = '{0, 0, 16'h0,    0, 1, 20'h20,    0, 20'h0,     0, 16'h0BEE, 0, 0, 20'h0};
        v[19] = '{0, 0, 16'h0,    0, 1, 20'h30,    0, 20'h0,     0, 16'h0BEE, 0, 1, 20'h20};
        v[20] = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h0BEE, 0, 1, 20'h30};
        v[21] = '{1, 0, 16'h0,    0, 1, 20'h40,    1, 20'h30,    0, 16'h0BEE, 0, 0, 20'h0};
        v[22] = '{1, 0, 16'h0,    0, 1, 20'h50,    1, 20'h30,    0, 16'h0BEE, 0, 1, 20'h40};
        v[23] = '{1, 1, 16'h9999, 0, 0, 20'h0,     1, 20'h40,    0, 16'h0BEE, 0, 1, 20'h50};
        v[24] = '{1, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h0BEE, 0, 0, 20'h0};
        v[25] = '{1, 1, 16'h7777, 1, 0, 20'h0,     1, 20'h50,    0, 16'h0BEE, 0, 0, 20'h0};
        v[26] = '{0, 0, 16'h0,    1, 0, 20'h0,     0, 20'h0,     1, 16'h7777, 1, 0, 20'h0};
        v[27] = '{0, 0, 16'h0,    0, 0, 20'h0,     0, 20'h0,     0, 16'h7777, 0, 0, 20'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", obs(), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].run, v[i].ack, v[i].rdata, v[i].rdy, v[i].br, v[i].tgt);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(),
                  {3'b0, v[i].req, v[i].addr, v[i].vld, v[i].ins, v[i].inc, v[i].ld, v[i].lval, 1'b0});
        end

        // reset in the middle of a fetch
        drive(1, 0, '0, 0, 0, '0);
        @(negedge clk);
        drive(1, 0, '0, 0, 0, '0);
        @(negedge clk);
        check("mid_req", {63'b0, mem_req}, 64'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_async", obs(), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_reset_idle", obs(), 64'h0);
        end
        drive(1, 0, '0, 0, 0, '0);
        drive(1, 0, '0, 0, 0, '0);
        @(negedge clk);
        check("restart_req", {43'b0, mem_req, mem_addr}, 64'h1_00000);

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        drive(1, 0, '0, 0, 0, '0);
        cnt = 0;
        for (int i = 0; i < 40 && !fault; i++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("timeout_cycles", 64'(cnt), 64'd15);
        check("timeout_fault", {62'b0, fault, mem_req}, 64'h2);
        repeat (5) begin
            drive(1, 1, '0, 1, 1, 20'h3);
            @(negedge clk);
            check("fault_sticky", {60'b0, fault, mem_req, instr_valid, ip_load}, 64'h8);
        end
        do_reset();
        @(negedge clk);
        check("fault_cleared", {63'b0, fault}, 64'h0);
`endif

        // randomized run against a fetch-stream model
        do_reset();
        exp_pc = '0;
        prev_br = 0;
        prev_tgt = '0;
        words = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            run = $urandom_range(0, 9) != 0;
            br_valid = $urandom_range(0, 19) == 0;
            br_target = AW'($urandom);
            instr_ready = (br_valid && instr_valid) ? 1'b0 : ($urandom_range(0, 9) < 6);
            mem_ack = mem_req && $urandom_range(0, 3) != 0;
            mem_rdata = mem_ack ? mem_word(mem_addr) : DW'($urandom);
            @(negedge clk);
            check("rand_inv", {ip_inc && ip_load, ip_load, ip_load_val, mem_addr, fault},
                  {1'b0, prev_br, prev_br ? prev_tgt : '0, mem_req ? ip : '0, 1'b0});
            if (instr_valid && instr_ready) begin
                check("rand_word", 64'(instr), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 1'b1;
                words++;
            end
            if (br_valid) exp_pc = br_target;
            prev_br = br_valid;
            prev_tgt = br_target;
        end
        check("rand_progress", 64'(words >= 100), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
